// File: rtl/parity_frame_ctrl.sv
// Parity frame controller: accepts a DATA_W-bit word on a valid/ready handshake and sends start, data (LSB first), parity, stop on TX.
// Latency: the start bit appears the cycle after the transfer edge; a frame lasts (DATA_W+3)*BIT_TICKS cycles, then one IDLE cycle.
// Backpressure: DIN_READY is high only in IDLE; the source holds DIN/DIN_VALID until accepted. Define PARITY_ODD_EN for odd parity.
module parity_frame_ctrl #(
  parameter int DATA_W    = 4,
  parameter int BIT_TICKS = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              TX,
  output logic              P,
  output logic              BUSY,
  output logic              DONE,
  output logic [7:0]        FRAME_CNT
);

  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TICK_PRE_I = (BIT_TICKS > 1) ? (BIT_TICKS - 2) : 0;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_PRE_I);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);
  localparam bit ONE_TICK = (BIT_TICKS == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [TW-1:0]     tick;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              bit_end;
  logic              done_set;
  logic              din_par;

  assign DIN_READY = (state == IDLE);
  assign bit_end   = (tick == TICK_LAST);
  assign shreg_nxt = shreg >> 1;

  // DONE is registered, so it is armed on the edge that enters the last stop-bit cycle.
  // With one tick per bit that edge is the end of the parity bit.
  assign done_set = ONE_TICK ? (state == PARITY) : ((state == STOP) && (tick == TICK_PRE));

  // Parity of the incoming word, sampled into P on the transfer edge.
  always_comb begin
`ifdef PARITY_ODD_EN
    din_par = ~(^DIN);
`else
    din_par = ^DIN;
`endif
  end

  // Frame sequencer: TX is registered and loaded with the next bit's level on each bit boundary.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      TX        <= 1'b1;
      P         <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FRAME_CNT <= 8'd0;
    end else begin
      DONE <= 1'b0;
      if (done_set) begin
        DONE      <= 1'b1;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      case (state)
        IDLE: begin
          if (DIN_VALID) begin
            shreg   <= DIN;
            P       <= din_par;
            state   <= START;
            BUSY    <= 1'b1;
            TX      <= 1'b0;
            tick    <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            tick  <= '0;
            state <= DATA;
            TX    <= shreg[0];
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            tick  <= '0;
            shreg <= shreg_nxt;
            if (bit_idx == IDX_LAST) begin
              state <= PARITY;
              TX    <= P;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              TX      <= shreg_nxt[0];
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            tick  <= '0;
            state <= STOP;
            TX    <= 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            tick    <= '0;
            bit_idx <= '0;
            state   <= IDLE;
            BUSY    <= 1'b0;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          TX    <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
